// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO sequencing controller. Accepts DIV/DIVU/MTHI/MTLO from EX, drives the
// shared unsigned divider via start/done, sign-corrects the results and writes HI/LO.
module muldiv_hilo_ctrl #(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        div_err
);
  localparam int CW = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIX} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          neg_q, neg_r;
  logic [31:0]   q_res, r_res;

  logic        is_div, is_signed, is_mthi, is_mtlo, b_zero, accept, timeout;
  logic [31:0] a_mag, b_mag;

  assign is_signed = (op_code == 3'b001);
  assign is_div    = (op_code == 3'b001) || (op_code == 3'b010);
  assign is_mthi   = (op_code == 3'b011);
  assign is_mtlo   = (op_code == 3'b100);
  assign b_zero    = (op_b == 32'd0);
  assign accept    = (state == IDLE) && op_valid && !flush;
  assign a_mag     = (is_signed && op_a[31]) ? -op_a : op_a;
  assign b_mag     = (is_signed && op_b[31]) ? -op_b : op_b;
  // done on the last allowed cycle still counts as done
  assign timeout   = (state == WAIT) && !div_done && (cnt == CW'(DIV_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_div && !b_zero) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (div_done)     state_nxt = FIX;
        else if (timeout) state_nxt = IDLE;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // FIX is deliberately not stalled so EX retires the DIV as HI/LO land
  assign stall     = (accept && is_div && !b_zero) || (state == ISSUE) || (state == WAIT);
  assign div_start = (state == ISSUE) && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hi           <= '0;
      lo           <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_err      <= 1'b0;
      cnt          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      q_res        <= '0;
      r_res        <= '0;
    end else begin
      state <= state_nxt;
      if (!flush) begin
        case (state)
          IDLE: if (accept) begin
            if (is_mthi) hi <= op_a;
            if (is_mtlo) lo <= op_a;
            if (is_div) begin
              if (b_zero) begin
                hi <= op_a;
                lo <= 32'hFFFF_FFFF;
              end else begin
                div_dividend <= a_mag;
                div_divisor  <= b_mag;
                neg_q        <= is_signed && (op_a[31] ^ op_b[31]);
                neg_r        <= is_signed && op_a[31];
              end
            end
          end
          ISSUE: cnt <= '0;
          WAIT: begin
            if (div_done) begin
              q_res <= neg_q ? -div_q : div_q;
              r_res <= neg_r ? -div_r : div_r;
            end else if (timeout) begin
              div_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FIX: begin
            hi <= r_res;
            lo <= q_res;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl; the divider is played by the bench with
// hand-computed quotient/remainder pulses.
module tb_muldiv_hilo_ctrl;
  logic        clock = 1'b0;
  logic        reset, flush, op_valid, div_done;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b, div_q, div_r;
  logic        stall, div_start, div_err;
  logic [31:0] hi, lo, div_dividend, div_divisor;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OP_DIV = 3'b001, OP_DIVU = 3'b010, OP_MTHI = 3'b011, OP_MTLO = 3'b100;

  muldiv_hilo_ctrl #(.DIV_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .flush(flush), .op_valid(op_valid),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .stall(stall), .hi(hi), .lo(lo),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_q(div_q), .div_r(div_r), .div_err(div_err)
  );

  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one op at cycle 0, pulse div_done at cycle done_c (<0: never), run ncyc cycles.
  task automatic do_div(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input int done_c,
                        input int ncyc, output int stalls, output int starts,
                        output int start_c, output logic [31:0] dvd, output logic [31:0] dvs);
    stalls = 0; starts = 0; start_c = -1; dvd = '0; dvs = '0;
    div_q = q; div_r = r;
    for (int c = 0; c < ncyc; c++) begin
      op_valid = (c == 0);
      op_code  = code; op_a = a; op_b = b;
      div_done = (c == done_c);
      #1;
      if (stall) stalls++;
      if (div_start) begin
        starts++;
        if (start_c < 0) start_c = c;
      end
      if (c == 1) begin
        dvd = div_dividend;
        dvs = div_divisor;
      end
      next_cycle();
    end
    op_valid = 1'b0; div_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0;
    div_done = 1'b0; div_q = '0; div_r = '0;
    #2;
    checks++;
    if ({hi, lo, div_dividend, div_divisor} !== 128'd0 || stall !== 1'b0 ||
        div_start !== 1'b0 || div_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: hi=%h lo=%h dvd=%h dvs=%h stall=%b start=%b err=%b, want all 0",
               hi, lo, div_dividend, div_divisor, stall, div_start, div_err);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_divu();
    int st, sp, sc; logic [31:0] dvd, dvs;
    do_div(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 4, 7, st, sp, sc, dvd, dvs);
    checks++;
    if (st !== 5) begin errors++; $display("FAIL divu_stall_cycles: got %0d want 5", st); end
    checks++;
    if (sp !== 1 || sc !== 1) begin
      errors++; $display("FAIL divu_start: pulses=%0d at %0d want 1 at 1", sp, sc);
    end
    checks++;
    if (dvd !== 32'd100 || dvs !== 32'd7) begin
      errors++; $display("FAIL divu_operands: got %h/%h want 64/7", dvd, dvs);
    end
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      errors++; $display("FAIL divu_result: hi=%h lo=%h want 2/e", hi, lo);
    end
  endtask

  task automatic test_div_signed();
    int st, sp, sc; logic [31:0] dvd, dvs;
    // minimum latency: done in first WAIT cycle
    do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd3, 32'd1, 2, 5, st, sp, sc, dvd, dvs);
    checks++;
    if (dvd !== 32'd7 || dvs !== 32'd2) begin
      errors++; $display("FAIL div_neg_a_operands: got %h/%h want 7/2", dvd, dvs);
    end
    checks++;
    if (st !== 3) begin errors++; $display("FAIL div_min_stall: got %0d want 3", st); end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg_a_result: hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
    end
    do_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd3, 32'd1, 3, 6, st, sp, sc, dvd, dvs);
    checks++;
    if (dvd !== 32'd7 || dvs !== 32'd2) begin
      errors++; $display("FAIL div_neg_b_operands: got %h/%h want 7/2", dvd, dvs);
    end
    checks++;
    if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg_b_result: hi=%h lo=%h want 1/fffffffd", hi, lo);
    end
  endtask

  task automatic test_overflow();
    int st, sp, sc; logic [31:0] dvd, dvs;
    do_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 3, 6, st, sp, sc, dvd, dvs);
    checks++;
    if (dvd !== 32'h8000_0000 || dvs !== 32'd1) begin
      errors++; $display("FAIL ovf_operands: got %h/%h want 80000000/1", dvd, dvs);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++; $display("FAIL ovf_result: hi=%h lo=%h want 0/80000000", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int st, sp, sc; logic [31:0] dvd, dvs;
    do_div(OP_DIV, 32'd5, 32'd0, 32'd0, 32'd0, -1, 3, st, sp, sc, dvd, dvs);
    checks++;
    if (st !== 0 || sp !== 0) begin
      errors++; $display("FAIL divzero_handshake: stalls=%0d starts=%0d want 0/0", st, sp);
    end
    checks++;
    if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divzero_result: hi=%h lo=%h want 5/ffffffff", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int st = 0;
    op_valid = 1'b1; op_code = OP_MTHI; op_a = 32'h1234;
    #1; if (stall) st++;
    next_cycle();
    checks++;
    if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_same_edge: hi=%h want 1234", hi); end
    op_code = OP_MTLO; op_a = 32'hABCD;
    #1; if (stall) st++;
    next_cycle();
    op_valid = 1'b0;
    checks++;
    if (hi !== 32'h1234 || lo !== 32'hABCD || st !== 0) begin
      errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h stalls=%0d want 1234/abcd/0", hi, lo, st);
    end
  endtask

  task automatic test_flush();
    int st, sp, sc, late_starts; logic [31:0] dvd, dvs;
    late_starts = 0;
    op_valid = 1'b1; op_code = OP_DIV; op_a = 32'd20; op_b = 32'd4;
    next_cycle();                       // accepted; now ISSUE
    op_valid = 1'b0;
    next_cycle();                       // WAIT 1
    next_cycle();                       // WAIT 2
    flush = 1'b1;
    #1; if (div_start) late_starts++;
    next_cycle();
    flush = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: stall=%b want 0", stall); end
    next_cycle();
    div_done = 1'b1; div_q = 32'd5; div_r = 32'd0;   // late pulse from the flushed divide
    #1; if (div_start || stall) late_starts++;
    next_cycle();
    div_done = 1'b0;
    next_cycle();
    #1; if (div_start || stall) late_starts++;
    checks++;
    if (hi !== 32'h1234 || lo !== 32'hABCD || late_starts !== 0) begin
      errors++; $display("FAIL flush_hold: hi=%h lo=%h spurious=%0d want 1234/abcd/0",
                         hi, lo, late_starts);
    end
    do_div(OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 2, 5, st, sp, sc, dvd, dvs);
    checks++;
    if (hi !== 32'd0 || lo !== 32'd3 || sp !== 1) begin
      errors++; $display("FAIL post_flush_divu: hi=%h lo=%h starts=%0d want 0/3/1", hi, lo, sp);
    end
  endtask

  task automatic test_timeout();
    int st, sp, sc; logic [31:0] dvd, dvs;
    checks++;
    if (div_err !== 1'b0) begin errors++; $display("FAIL err_pre: err=%b want 0", div_err); end
    do_div(OP_DIVU, 32'd50, 32'd5, 32'd10, 32'd0, -1, 12, st, sp, sc, dvd, dvs);
    checks++;
    if (st !== 10) begin errors++; $display("FAIL timeout_stall: got %0d want 10", st); end
    checks++;
    if (div_err !== 1'b1 || stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd3) begin
      errors++; $display("FAIL timeout: err=%b stall=%b hi=%h lo=%h want 1/0/0/3",
                         div_err, stall, hi, lo);
    end
    div_done = 1'b1; div_q = 32'd10; div_r = 32'd0;
    next_cycle();
    div_done = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (div_err !== 1'b1 || hi !== 32'd0 || lo !== 32'd3) begin
      errors++; $display("FAIL err_sticky: err=%b hi=%h lo=%h want 1/0/3", div_err, hi, lo);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (div_err !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_clears: err=%b hi=%h lo=%h want 0/0/0", div_err, hi, lo);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
